out_port_fnd_driver: RTL and testbench

Display stage downstream of the summation datapath: consumes the registered 8-bit `OutPort` result and shows it in decimal on a 4-digit common-anode 7-segment (FND) module. Sequential double-dabble converts binary to 3 BCD digits. A tick-divided scanner time-multiplexes the digits, blanking leading zeros. It is purely a consumer with no backpressure: it tracks whatever value the datapath presents.

---
 rtl/fnd_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/out_port_fnd_driver.sv | 114 +++++++++++
 tb/tb_out_port_fnd_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the OutPort FND display stage.
package fnd_pkg;

    // Binary-to-BCD conversion sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } conv_state_t;

    // Active-low segment and digit-enable "all off" patterns
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [3:0] COM_OFF    = 4'b1111;

    // Active-low {dp,g,f,e,d,c,b,a} codes for digits 0..9, dp off
    localparam logic [7:0] FONT_LUT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Segment code for one BCD digit; non-decimal nibbles show blank
    function automatic logic [7:0] font_of(input logic [3:0] d);
        logic [7:0] f;
        f = FONT_BLANK;
        if (d < 4'd10) f = FONT_LUT[d];
        return f;
    endfunction

    // Double-dabble correction applied to a nibble before each shift
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one bit per cycle.
// A change seen while busy is remembered and converted once the current
// conversion has been published, so the last presented value always wins.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_din,
    input  logic        i_diff,
    output logic        o_load,
    output logic [11:0] o_bcd,
    output logic        o_busy
);

    conv_state_t r_state;
    conv_state_t w_nstate;
    logic [7:0]  r_bin;
    logic [11:0] r_scr;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_pending;
    logic        r_busy;
    logic        w_load;
    logic        w_shift;
    logic        w_update;
    logic [11:0] w_adj;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nstate;
    end

    // Next-state and per-state control strobes
    always_comb begin
        w_nstate = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_update = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_diff || r_pending) begin
                    w_load   = 1'b1;
                    w_nstate = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == 3'd7) w_nstate = UPDATE;
            end
            UPDATE: begin
                w_update = 1'b1;
                w_nstate = IDLE;
            end
            default: w_nstate = IDLE;
        endcase
    end

    // Per-nibble add-3 on the scratch digits ahead of the shift
    always_comb begin
        w_adj = {dabble(r_scr[11:8]), dabble(r_scr[7:4]), dabble(r_scr[3:0])};
    end

    // Conversion datapath, pending flag and published result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin     <= '0;
            r_scr     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= (w_nstate != IDLE);
            if (w_load) begin
                r_bin <= i_din;
                r_scr <= '0;
                r_cnt <= '0;
            end
            if (w_shift) begin
                {r_scr, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 3'd1;
            end
            if (w_update) r_bcd <= r_scr;
            // A new value arriving mid-conversion is deferred, not dropped
            if (w_load)                        r_pending <= 1'b0;
            else if (r_state != IDLE && i_diff) r_pending <= 1'b1;
        end
    end

    assign o_load = w_load;
    assign o_bcd  = r_bcd;
    assign o_busy = r_busy;

endmodule

// File: rtl/out_port_fnd_driver.sv
// Shows the datapath OutPort value in decimal on a 4-digit common-anode
// FND: change detect feeds the BCD converter, a tick divider scans digits,
// and leading zeros are blanked.
module out_port_fnd_driver
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_font
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("out_port_fnd_driver: CLK_HZ/SCAN_HZ must be at least 2");
        end
    endgenerate

    logic [7:0]    r_last_val;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_idx;
    logic [3:0]    r_com;
    logic [7:0]    r_font;
    logic [3:0]    w_com;
    logic [7:0]    w_font;
    logic          w_diff;
    logic          w_load;
    logic [11:0]   w_bcd;
    logic [3:0]    w_ones;
    logic [3:0]    w_tens;
    logic [3:0]    w_huns;

    assign w_diff = (data_in != r_last_val);

    bin2bcd_seq u_conv (
        .clk    (clk),
        .reset  (reset),
        .i_din  (data_in),
        .i_diff (w_diff),
        .o_load (w_load),
        .o_bcd  (w_bcd),
        .o_busy (busy)
    );

    assign bcd    = w_bcd;
    assign w_ones = w_bcd[3:0];
    assign w_tens = w_bcd[7:4];
    assign w_huns = w_bcd[11:8];

    // Remember the value the converter last accepted for change detection
    always_ff @(posedge clk) begin
        if (!reset)      r_last_val <= '0;
        else if (w_load) r_last_val <= data_in;
    end

    // Scan tick divider and digit index
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Digit enable and font select with leading-zero blanking
    always_comb begin
        w_com  = COM_OFF;
        w_font = FONT_BLANK;
        case (r_idx)
            2'd0: begin
                w_com  = 4'b1110;
                w_font = font_of(w_ones);
            end
            2'd1: begin
                w_com = 4'b1101;
                if (w_huns != 4'd0 || w_tens != 4'd0) w_font = font_of(w_tens);
            end
            2'd2: begin
                w_com = 4'b1011;
                if (w_huns != 4'd0) w_font = font_of(w_huns);
            end
            default: ;
        endcase
    end

    // Register the drive so segments and commons switch together
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_com  <= COM_OFF;
            r_font <= FONT_BLANK;
        end else begin
            r_com  <= w_com;
            r_font <= w_font;
        end
    end

    assign fnd_com  = r_com;
    assign fnd_font = r_font;

endmodule

// File: tb/tb_out_port_fnd_driver.sv
// Bench for out_port_fnd_driver with DIV = 10. Expected display state is
// derived from decimal arithmetic on the value that should be on screen and
// from the number of clocks since reset release.
module tb_out_port_fnd_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_font;

    int n_chk  = 0;
    int n_pass = 0;
    int k      = 0;   // clocks since reset release
    int m_val  = 0;   // decimal value bcd should hold
    int last_v = 0;   // last value handed to the converter
    logic [7:0] font_ref [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    out_port_fnd_driver #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .bcd      (bcd),
        .busy     (busy),
        .fnd_com  (fnd_com),
        .fnd_font (fnd_font)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Digit shown after the kk-th clock since release (one clock of register lag)
    function automatic int scan_idx(input int kk);
        return ((kk - 1) / 10) % 4;
    endfunction

    function automatic int ref_com(input int kk);
        int idx;
        if (kk == 0) return 15;
        idx = scan_idx(kk);
        if (idx == 3) return 15;
        return 15 & ~(1 << idx);
    endfunction

    function automatic int ref_font(input int kk, input int v);
        int idx;
        if (kk == 0) return 255;
        idx = scan_idx(kk);
        case (idx)
            0: return int'(font_ref[v % 10]);
            1: return (v < 10)  ? 255 : int'(font_ref[(v / 10) % 10]);
            2: return (v < 100) ? 255 : int'(font_ref[v / 100]);
            default: return 255;
        endcase
    endfunction

    // One clock; scan outputs reflect the value displayed before this edge
    task automatic cycle();
        int  prev;
        bit  rst_e;
        prev  = m_val;
        rst_e = !reset;
        @(posedge clk);
        if (rst_e) begin
            k     = 0;
            m_val = 0;
        end else begin
            k++;
        end
        @(negedge clk);
        chk("com", 32'(fnd_com), ref_com(k));
        chk("font", 32'(fnd_font), ref_font(k, prev));
    endtask

    task automatic scan_run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Present a new value while idle; result must land 9 edges after load
    task automatic run_conv(input int v);
        data_in = 8'(v);
        cycle();
        chk("busy_rise", 32'(busy), 1);
        for (int i = 1; i <= 8; i++) cycle();
        chk("busy_mid", 32'(busy), 1);
        chk("bcd_hold", 32'(bcd), to_bcd(m_val));
        cycle();
        m_val = v;
        chk("bcd", 32'(bcd), to_bcd(m_val));
        chk("busy_fall", 32'(busy), 0);
        last_v = v;
    endtask

    // v1 loaded, then v2 presented d clocks in; v2 must follow 10 clocks later
    task automatic run_pend(input int v1, input int d, input int v2);
        data_in = 8'(v1);
        cycle();
        chk("pend_busy_rise", 32'(busy), 1);
        for (int i = 1; i <= d; i++) cycle();
        data_in = 8'(v2);
        for (int i = d + 1; i <= 9; i++) cycle();
        m_val = v1;
        chk("pend_bcd1", 32'(bcd), to_bcd(v1));
        chk("pend_busy_fall1", 32'(busy), 0);
        for (int j = 10; j <= 18; j++) begin
            cycle();
            chk("pend_bcd_hold", 32'(bcd), to_bcd(v1));
            if (j == 10) chk("pend_busy_rise2", 32'(busy), 1);
        end
        cycle();
        m_val = v2;
        chk("pend_bcd2", 32'(bcd), to_bcd(v2));
        chk("pend_busy_fall2", 32'(busy), 0);
        last_v = v2;
    endtask

    initial begin
        int v, v2, d;

        // Reset for 3 clocks with a zero input
        reset   = 1'b0;
        data_in = 8'd0;
        scan_run(3);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        for (int i = 0; i < 45; i++) begin
            cycle();
            chk("idle_busy", 32'(busy), 0);
        end
        chk("idle_bcd", 32'(bcd), 0);

        // Directed values
        run_conv(55);
        scan_run(40);
        run_conv(255);
        scan_run(40);
        run_conv(100);
        scan_run(40);

        // Change arriving three clocks into a conversion
        run_pend(7, 3, 200);
        scan_run(5);

        // Reset landing on the fourth shift of 123
        data_in = 8'd123;
        cycle();
        scan_run(3);
        reset = 1'b0;
        cycle();
        chk("midrst_bcd", 32'(bcd), 0);
        chk("midrst_busy", 32'(busy), 0);
        reset  = 1'b1;
        last_v = 0;
        run_conv(123);
        scan_run(40);

        // Random values with random idle gaps
        for (int r = 0; r < 8; r++) begin
            do v = int'($urandom_range(255)); while (v == last_v);
            run_conv(v);
            scan_run(int'($urandom_range(12)));
        end

        // Random mid-conversion changes
        for (int r = 0; r < 4; r++) begin
            do v = int'($urandom_range(255)); while (v == last_v);
            do v2 = int'($urandom_range(255)); while (v2 == v);
            d = int'($urandom_range(8));
            run_pend(v, d, v2);
            scan_run(int'($urandom_range(12)));
        end

        scan_run(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
